// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory bus bridge: default widths,
// byte-strobe constants and the transaction state encoding.
package data_mem_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 32;
  localparam int STRB_W     = DEF_DWIDTH / 8;
  localparam logic [STRB_W-1:0] STRB_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/data_mem_bus_if_if.sv
// Valid/ready memory bus: one request channel (address, write enable,
// strobes, write data) and one response channel (read data, error).
interface data_mem_bus_if_if
  import data_mem_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [AWIDTH-1:0]     req_addr;
  logic                  req_we;
  logic [DWIDTH/8-1:0]   req_strb;
  logic [DWIDTH-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DWIDTH-1:0]     rsp_rdata;
  logic                  rsp_err;

  // Bridge side: issues requests, consumes responses.
  modport master (
    output req_valid, req_addr, req_we, req_strb, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, returns responses.
  modport slave (
    input  req_valid, req_addr, req_we, req_strb, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_timeout_ctr.sv
// Transaction watchdog: cleared when a transaction starts, counts every
// cycle spent waiting on the bus, and flags the last permitted cycle.
module data_mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count waiting cycles; restart at zero for each new transaction.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values no matter how statements are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_bus_if.sv
// Bridge from the core's single-cycle data-memory port to a valid/ready
// bus. Stalls the core for the whole transaction and reports bus errors
// and watchdog expiry as a one-cycle fault when the access completes.
module data_mem_bus_if
  import data_mem_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [AWIDTH-1:0]   Mem_Addr,
  input  logic                Mem_Read_En,
  input  logic [DWIDTH/8-1:0] Mem_Write_Ctrl,
  input  logic [DWIDTH-1:0]   Mem_Write_Data,
  output logic [DWIDTH-1:0]   Data_Mem_Read,
  output logic                Mem_Stall,
  output logic                Mem_Fault,
  data_mem_bus_if_if.master   bus
);

  localparam int SW = DWIDTH / 8;
  localparam logic [SW-1:0] STRB_READ = '1;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] REQ  = ST_REQ;
  localparam logic [1:0] RSP  = ST_RSP;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]        state;
  logic              access;
  logic              is_write;
  logic              tmo_clear;
  logic              tmo_enable;
  logic              tmo_expire;
  logic              fault_q;
  logic [AWIDTH-1:0] req_addr_q;
  logic              req_we_q;
  logic [SW-1:0]     req_strb_q;
  logic [DWIDTH-1:0] req_wdata_q;
  logic [1:0]        unused_addr_lsb;

  // Requests are word aligned, so the byte offset is not forwarded.
  assign unused_addr_lsb = Mem_Addr[1:0];

  // A store wins over a load when both are requested.
  assign is_write = |Mem_Write_Ctrl;
  assign access   = Mem_Read_En | is_write;

  assign tmo_clear  = (state == IDLE) && access;
  assign tmo_enable = (state == REQ) || (state == RSP);

  data_mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (Clk),
    .rst    (Reset),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  // Transaction FSM with request capture and read-data/fault registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      req_addr_q    <= '0;
      req_we_q      <= 1'b0;
      req_strb_q    <= '0;
      req_wdata_q   <= '0;
      Data_Mem_Read <= '0;
      fault_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            req_addr_q  <= {Mem_Addr[AWIDTH-1:2], 2'b00};
            req_we_q    <= is_write;
            req_strb_q  <= is_write ? Mem_Write_Ctrl : STRB_READ;
            req_wdata_q <= Mem_Write_Data;
            state       <= REQ;
          end
        end
        REQ: begin
          // Watchdog expiry beats a same-cycle acceptance.
          if (tmo_expire) begin
            fault_q       <= 1'b1;
            Data_Mem_Read <= '0;
            state         <= DONE;
          end else if (bus.req_ready) begin
            state <= RSP;
          end
        end
        RSP: begin
          // A response on the last permitted cycle still completes normally.
          if (bus.rsp_valid) begin
            fault_q <= bus.rsp_err;
            if (bus.rsp_err) begin
              Data_Mem_Read <= '0;
            end else if (!req_we_q) begin
              Data_Mem_Read <= bus.rsp_rdata;
            end
            state <= DONE;
          end else if (tmo_expire) begin
            fault_q       <= 1'b1;
            Data_Mem_Read <= '0;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_valid = (state == REQ);
  assign bus.req_addr  = req_addr_q;
  assign bus.req_we    = req_we_q;
  assign bus.req_strb  = req_strb_q;
  assign bus.req_wdata = req_wdata_q;

  // Stall is gated by reset so the core is released the moment reset hits,
  // even if it is still presenting an access.
  assign Mem_Stall = !Reset &&
                     ((state == REQ) || (state == RSP) || ((state == IDLE) && access));
  assign Mem_Fault = (state == DONE) && fault_q;

endmodule

// File: tb/tb_data_mem_bus_if.sv
// Self-checking bench for data_mem_bus_if: directed vector table, hand
// sequences for reset and late-response corners, then randomized traffic
// against a word-level memory model.
module tb_data_mem_bus_if;
  import data_mem_pkg::*;

  localparam int T = 8;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd_en;
    logic [3:0]  wctrl;
    logic [31:0] wdata;
    int          rd;        // cycles Ready stays low in REQ
    int          sd;        // extra cycles before the response in RSP
    logic        err;
    logic        use_mem;   // response data from the bus memory model
    logic [31:0] rsp_rdata;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_strb;
    int          e_done;    // cycle index of DONE (access cycle = 0)
    logic        e_fault;
    logic [31:0] e_rdata;
  } vec_t;

  logic        Clk;
  logic        Reset;
  logic [31:0] Mem_Addr;
  logic        Mem_Read_En;
  logic [3:0]  Mem_Write_Ctrl;
  logic [31:0] Mem_Write_Data;
  logic [31:0] Data_Mem_Read;
  logic        Mem_Stall;
  logic        Mem_Fault;

  data_mem_bus_if_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  data_mem_bus_if #(
    .DWIDTH  (32),
    .AWIDTH  (32),
    .TIMEOUT (T)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Mem_Addr       (Mem_Addr),
    .Mem_Read_En    (Mem_Read_En),
    .Mem_Write_Ctrl (Mem_Write_Ctrl),
    .Mem_Write_Data (Mem_Write_Data),
    .Data_Mem_Read  (Data_Mem_Read),
    .Mem_Stall      (Mem_Stall),
    .Mem_Fault      (Mem_Fault),
    .bus            (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_dmr = 32'h0;

  logic [31:0] ref_mem   [int unsigned];
  logic [31:0] slave_mem [int unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input int unsigned idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned idx;
    idx = a >> 2;
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    int unsigned idx;
    idx = a >> 2;
    return slave_mem.exists(idx) ? slave_mem[idx] : init_word(idx);
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] addr, input logic rd_en,
                              input logic [3:0] wctrl, input logic [31:0] wdata,
                              input int rd, input int sd, input logic err,
                              input logic [31:0] rsp, input logic [31:0] e_addr,
                              input logic e_we, input logic [3:0] e_strb, input int e_done,
                              input logic e_fault, input logic [31:0] e_rdata);
    vec_t v;
    v.name = n; v.addr = addr; v.rd_en = rd_en; v.wctrl = wctrl; v.wdata = wdata;
    v.rd = rd; v.sd = sd; v.err = err; v.use_mem = 1'b0; v.rsp_rdata = rsp;
    v.e_addr = e_addr; v.e_we = e_we; v.e_strb = e_strb; v.e_done = e_done;
    v.e_fault = e_fault; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Reference model: derives the expected bus request, completion cycle,
  // fault and returned word from the access and bus timing, and applies
  // successful stores to the reference memory.
  function automatic vec_t gen(input string n, input logic [31:0] addr, input logic rd_en,
                               input logic [3:0] wctrl, input logic [31:0] wdata,
                               input int rd, input int sd, input logic err);
    vec_t v;
    logic is_wr, tmo;
    is_wr = (wctrl != 4'h0);
    tmo   = (rd + sd) > (T - 2);
    v = mk(n, addr, rd_en, wctrl, wdata, rd, sd, err, 32'h0,
           addr & 32'hFFFF_FFFC, is_wr, is_wr ? wctrl : STRB_ALL,
           tmo ? T + 1 : 3 + rd + sd, tmo | err, 32'h0);
    v.use_mem = 1'b1;
    if (tmo || err) v.e_rdata = 32'h0;
    else if (is_wr) v.e_rdata = exp_dmr;
    else v.e_rdata = ref_rd(addr);
    if (!tmo && !err && is_wr) ref_mem[addr >> 2] = merge(ref_rd(addr), wdata, wctrl);
    return v;
  endfunction

  // Runs one access from the IDLE cycle through DONE, acting as the core
  // and as the bus memory, and checks the observable behaviour each cycle.
  task automatic run_txn(input vec_t v);
    logic        acc;
    logic [31:0] a_addr, a_wdata;
    logic        a_we;
    logic [3:0]  a_strb;
    acc = 1'b0; a_addr = '0; a_wdata = '0; a_we = 1'b0; a_strb = '0;
    for (int cyc = 0; cyc <= v.e_done; cyc++) begin
      if (cyc == 0) begin
        Mem_Addr = v.addr; Mem_Read_En = v.rd_en;
        Mem_Write_Ctrl = v.wctrl; Mem_Write_Data = v.wdata;
      end else if (cyc < v.e_done) begin
        Mem_Addr = $urandom; Mem_Read_En = 1'($urandom);
        Mem_Write_Ctrl = 4'($urandom); Mem_Write_Data = $urandom;
      end else begin
        Mem_Read_En = 1'b0; Mem_Write_Ctrl = 4'h0;
      end
      bus.req_ready = (cyc == 1 + v.rd);
      if (cyc == 2 + v.rd + v.sd && cyc < v.e_done) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = v.err;
        if (v.use_mem) begin
          bus.rsp_rdata = acc ? slave_rd(a_addr) : $urandom;
          if (acc && a_we && !v.err)
            slave_mem[a_addr >> 2] = merge(slave_rd(a_addr), a_wdata, a_strb);
        end else begin
          bus.rsp_rdata = v.rsp_rdata;
        end
      end else begin
        bus.rsp_valid = (cyc >= 1 && cyc <= 1 + v.rd && cyc < v.e_done) ? 1'($urandom) : 1'b0;
        bus.rsp_err   = 1'($urandom);
        bus.rsp_rdata = $urandom;
      end
      #1;
      if (cyc == 0) begin
        check($sformatf("%s.stall@0", v.name), Mem_Stall, 1'b1);
        check($sformatf("%s.valid@0", v.name), bus.req_valid, 1'b0);
        check($sformatf("%s.fault@0", v.name), Mem_Fault, 1'b0);
        check($sformatf("%s.dmr_hold@0", v.name), Data_Mem_Read, exp_dmr);
      end else if (cyc < v.e_done) begin
        check($sformatf("%s.stall@%0d", v.name, cyc), Mem_Stall, 1'b1);
        check($sformatf("%s.fault@%0d", v.name, cyc), Mem_Fault, 1'b0);
        check($sformatf("%s.valid@%0d", v.name, cyc), bus.req_valid, cyc <= 1 + v.rd);
        if (bus.req_valid) begin
          check($sformatf("%s.addr@%0d", v.name, cyc), bus.req_addr, v.e_addr);
          check($sformatf("%s.we@%0d", v.name, cyc), bus.req_we, v.e_we);
          check($sformatf("%s.strb@%0d", v.name, cyc), bus.req_strb, v.e_strb);
          check($sformatf("%s.wdata@%0d", v.name, cyc), bus.req_wdata, v.wdata);
          if (bus.req_ready) begin
            acc = 1'b1; a_addr = bus.req_addr; a_we = bus.req_we;
            a_strb = bus.req_strb; a_wdata = bus.req_wdata;
          end
        end
      end else begin
        check($sformatf("%s.done_stall", v.name), Mem_Stall, 1'b0);
        check($sformatf("%s.done_valid", v.name), bus.req_valid, 1'b0);
        check($sformatf("%s.done_fault", v.name), Mem_Fault, v.e_fault);
        check($sformatf("%s.done_rdata", v.name), Data_Mem_Read, v.e_rdata);
      end
      @(negedge Clk);
    end
    exp_dmr = v.e_rdata;
    Mem_Read_En = 1'b0; Mem_Write_Ctrl = 4'h0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    Mem_Addr = 32'h0; Mem_Read_En = 1'b1; Mem_Write_Ctrl = 4'h0; Mem_Write_Data = 32'h0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = 32'h0; bus.rsp_err = 1'b0;

    // Reset state, with a load presented to show stall is held low.
    #2;
    check("rst.dmr", Data_Mem_Read, 32'h0);
    check("rst.stall", Mem_Stall, 1'b0);
    check("rst.fault", Mem_Fault, 1'b0);
    check("rst.valid", bus.req_valid, 1'b0);
    check("rst.addr", bus.req_addr, 32'h0);
    check("rst.strb", bus.req_strb, 4'h0);
    check("rst.we", bus.req_we, 1'b0);
    check("rst.wdata", bus.req_wdata, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0; Mem_Read_En = 1'b0;
    @(negedge Clk);

    // name, addr, rd_en, wctrl, wdata, rd, sd, err, rsp | e_addr, we, strb, done, fault, rdata
    vecs[0] = mk("lw_104",   32'h104, 1, 4'h0, 32'h0, 0, 0, 0, 32'hDEADBEEF,
                 32'h104, 0, 4'hF, 3, 0, 32'hDEADBEEF);
    vecs[1] = mk("sb_203",   32'h203, 0, 4'h8, 32'hAB000000, 4, 0, 0, 32'h55555555,
                 32'h200, 1, 4'h8, 7, 0, 32'hDEADBEEF);
    vecs[2] = mk("lw_err",   32'h008, 1, 4'h0, 32'h0, 0, 1, 1, 32'h12345678,
                 32'h008, 0, 4'hF, 4, 1, 32'h0);
    vecs[3] = mk("rd_wr",    32'h02E, 1, 4'h3, 32'h0000BEEF, 1, 1, 0, 32'hFFFFFFFF,
                 32'h02C, 1, 4'h3, 5, 0, 32'h0);
    vecs[4] = mk("lh_top",   32'h7FFFFFFE, 1, 4'h0, 32'hA5A5A5A5, 2, 2, 0, 32'hCAFEF00D,
                 32'h7FFFFFFC, 0, 4'hF, 7, 0, 32'hCAFEF00D);
    vecs[5] = mk("sw_err",   32'h040, 0, 4'hF, 32'h11223344, 0, 0, 1, 32'h0,
                 32'h040, 1, 4'hF, 3, 1, 32'h0);
    vecs[6] = mk("last_ok",  32'h080, 1, 4'h0, 32'h0, 3, 3, 0, 32'h0BADCAFE,
                 32'h080, 0, 4'hF, 9, 0, 32'h0BADCAFE);
    vecs[7] = mk("to_nrdy",  32'h084, 1, 4'h0, 32'h0, 20, 0, 0, 32'h77777777,
                 32'h084, 0, 4'hF, 9, 1, 32'h0);
    vecs[8] = mk("to_nrsp",  32'h088, 1, 4'h0, 32'h0, 0, 20, 0, 32'h66666666,
                 32'h088, 0, 4'hF, 9, 1, 32'h0);
    foreach (vecs[i]) run_txn(vecs[i]);

    // A response arriving after the watchdog fired is ignored.
    for (int i = 0; i < 4; i++) begin
      bus.rsp_valid = (i < 2); bus.rsp_err = 1'b0; bus.rsp_rdata = $urandom;
      #1;
      check($sformatf("late.stall@%0d", i), Mem_Stall, 1'b0);
      check($sformatf("late.valid@%0d", i), bus.req_valid, 1'b0);
      check($sformatf("late.fault@%0d", i), Mem_Fault, 1'b0);
      check($sformatf("late.dmr@%0d", i), Data_Mem_Read, 32'h0);
      @(negedge Clk);
    end
    bus.rsp_valid = 1'b0;

    // Reset while waiting in RSP releases the core without a clock edge.
    Mem_Addr = 32'h300; Mem_Read_En = 1'b1;
    @(negedge Clk);
    bus.req_ready = 1'b1;
    #1 check("mid_rst.valid_req", bus.req_valid, 1'b1);
    @(negedge Clk);
    bus.req_ready = 1'b0;
    #1 check("mid_rst.valid_rsp", bus.req_valid, 1'b0);
    check("mid_rst.stall_rsp", Mem_Stall, 1'b1);
    #1 Reset = 1'b1;
    #1;
    check("mid_rst.valid", bus.req_valid, 1'b0);
    check("mid_rst.stall", Mem_Stall, 1'b0);
    check("mid_rst.fault", Mem_Fault, 1'b0);
    @(negedge Clk);
    Reset = 1'b0; Mem_Read_En = 1'b0; Mem_Write_Ctrl = 4'h0;
    exp_dmr = 32'h0;
    #1;
    check("post_rst.valid", bus.req_valid, 1'b0);
    check("post_rst.stall", Mem_Stall, 1'b0);
    @(negedge Clk);
    run_txn(gen("post_rst_lw", 32'h300, 1, 4'h0, 32'h0, 0, 0, 0));

    // Back-to-back store then load of the same word.
    run_txn(gen("b2b_sw", 32'h10, 0, 4'hF, 32'hFEEDC0DE, 0, 0, 0));
    run_txn(gen("b2b_lw", 32'h10, 1, 4'h0, 32'h0, 1, 0, 0));

    // Randomized traffic over a small set of words.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic        rden;
      logic [3:0]  wc;
      int          rd, sd;
      logic        err;
      a  = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) begin
        rden = 1'b1; wc = 4'h0;
      end else begin
        rden = 1'($urandom); wc = 4'($urandom_range(1, 15));
      end
      rd  = $urandom_range(0, 3);
      sd  = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 3);
      err = ($urandom_range(0, 7) == 0);
      run_txn(gen($sformatf("rnd%0d", n), a, rden, wc, $urandom, rd, sd, err));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
